// File: rtl/lookup_result_display_if.sv
// Bus between the associative buffer side (request/data) and the result display.
// The master drives the button and buffer response; the slave drives the strobe, LEDs and FSM debug state.
interface lookup_result_display_if #(
   parameter int DATA_WIDTH = 2
);
   logic                  lookup_request;
   logic [DATA_WIDTH-1:0] data_input;
   logic                  data_valid_input;
   logic                  trigger_read;
   logic [DATA_WIDTH-1:0] leds_data;
   logic                  led_hit;
   logic                  led_miss;
   logic                  busy;
   logic [2:0]            state_dbg;

   modport master (
      output lookup_request, data_input, data_valid_input,
      input  trigger_read, leds_data, led_hit, led_miss, busy, state_dbg
   );

   modport slave (
      input  lookup_request, data_input, data_valid_input,
      output trigger_read, leds_data, led_hit, led_miss, busy, state_dbg
   );
endinterface

// File: rtl/lookup_result_display.sv
// Button-driven lookup of the associative buffer: one-cycle read strobe, bounded wait for
// the response, then a timed LED display of the hit data or a blinking miss indicator.
module lookup_result_display #(
   parameter int DATA_WIDTH        = 2,
   parameter int TIMEOUT_CYCLES    = 16,
   parameter int HOLD_CYCLES       = 25000000,
   parameter int BLINK_HALF_CYCLES = 6250000
) (
   input  logic                   clk,
   input  logic                   sync_reset_n,
   lookup_result_display_if.slave bus
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] REQUEST   = 3'd1;
   localparam logic [2:0] WAIT      = 3'd2;
   localparam logic [2:0] SHOW_HIT  = 3'd3;
   localparam logic [2:0] SHOW_MISS = 3'd4;

   localparam int WAIT_W  = (TIMEOUT_CYCLES    > 1) ? $clog2(TIMEOUT_CYCLES)    : 1;
   localparam int HOLD_W  = (HOLD_CYCLES       > 1) ? $clog2(HOLD_CYCLES)       : 1;
   localparam int BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;

   localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);

   logic [2:0]            state_q, state_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic [BLINK_W-1:0]    blink_q, blink_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  miss_q, miss_d;
   logic                  prev_q;
   logic                  req_edge;

   assign req_edge = bus.lookup_request & ~prev_q;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      hold_d  = hold_q;
      blink_d = blink_q;
      data_d  = data_q;
      miss_d  = miss_q;
      case (state_q)
         IDLE: begin
            if (req_edge) state_d = REQUEST;
         end
         REQUEST: begin
            wait_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A response arriving on the last wait cycle still counts as a hit.
            if (bus.data_valid_input) begin
               data_d  = bus.data_input;
               hold_d  = '0;
               state_d = SHOW_HIT;
            end else if (wait_q == WAIT_LAST) begin
               data_d  = '0;
               hold_d  = '0;
               blink_d = '0;
               miss_d  = 1'b1;
               state_d = SHOW_MISS;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         SHOW_HIT: begin
            if (req_edge || hold_q == HOLD_LAST) begin
               data_d  = '0;
               hold_d  = '0;
               blink_d = '0;
               state_d = req_edge ? REQUEST : IDLE;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         SHOW_MISS: begin
            if (req_edge || hold_q == HOLD_LAST) begin
               miss_d  = 1'b0;
               data_d  = '0;
               hold_d  = '0;
               blink_d = '0;
               state_d = req_edge ? REQUEST : IDLE;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
               if (blink_q == BLINK_LAST) begin
                  blink_d = '0;
                  miss_d  = ~miss_q;
               end else begin
                  blink_d = blink_q + BLINK_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            data_d  = '0;
            miss_d  = 1'b0;
            hold_d  = '0;
            blink_d = '0;
            wait_d  = '0;
         end
      endcase
   end

   // prev resets high so a button held through reset does not start a lookup.
   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         state_q <= IDLE;
         wait_q  <= '0;
         hold_q  <= '0;
         blink_q <= '0;
         data_q  <= '0;
         miss_q  <= 1'b0;
         prev_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         hold_q  <= hold_d;
         blink_q <= blink_d;
         data_q  <= data_d;
         miss_q  <= miss_d;
         prev_q  <= bus.lookup_request;
      end
   end

   assign bus.trigger_read = (state_q == REQUEST);
   assign bus.leds_data    = data_q;
   assign bus.led_hit      = (state_q == SHOW_HIT);
   assign bus.led_miss     = miss_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_lookup_result_display.sv
// Directed bench for lookup_result_display with small timing parameters so every
// phase (wait, timeout, hold, blink, retrigger, reset) is walked cycle by cycle.
module tb_lookup_result_display;

   localparam int DW = 2;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_REQUEST   = 3'd1;
   localparam logic [2:0] S_WAIT      = 3'd2;
   localparam logic [2:0] S_SHOW_HIT  = 3'd3;
   localparam logic [2:0] S_SHOW_MISS = 3'd4;

   logic clk;
   logic sync_reset_n;
   int   errors;
   int   checks;
   logic [7:0] miss_pat;

   lookup_result_display_if #(.DATA_WIDTH(DW)) bus ();

   lookup_result_display #(
      .DATA_WIDTH       (DW),
      .TIMEOUT_CYCLES   (4),
      .HOLD_CYCLES      (8),
      .BLINK_HALF_CYCLES(2)
   ) dut (
      .clk         (clk),
      .sync_reset_n(sync_reset_n),
      .bus         (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic expect_out(input string tag, input logic trig, input logic [DW-1:0] data,
                             input logic hit, input logic miss, input logic busy);
      check_eq({tag, ".trigger_read"}, 32'(bus.trigger_read), 32'(trig));
      check_eq({tag, ".leds_data"},    32'(bus.leds_data),    32'(data));
      check_eq({tag, ".led_hit"},      32'(bus.led_hit),      32'(hit));
      check_eq({tag, ".led_miss"},     32'(bus.led_miss),     32'(miss));
      check_eq({tag, ".busy"},         32'(bus.busy),         32'(busy));
   endtask

   task automatic expect_state(input string tag, input logic [2:0] st);
      check_eq({tag, ".state"}, 32'(bus.state_dbg), 32'(st));
   endtask

   // Advance one clock; inputs change and outputs are sampled 2ns after the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      miss_pat = 8'b0011_0011;
      sync_reset_n         = 1'b0;
      bus.lookup_request   = 1'b0;
      bus.data_input       = '0;
      bus.data_valid_input = 1'b0;

      // Reset then hit
      repeat (3) tick();
      expect_out("reset", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      expect_state("reset", S_IDLE);
      sync_reset_n = 1'b1;
      tick();
      bus.lookup_request = 1'b1;
      tick();
      expect_out("hit.req", 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      bus.lookup_request = 1'b0;
      tick();
      expect_out("hit.wait0", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      tick();
      bus.data_valid_input = 1'b1;
      bus.data_input       = 2'b10;
      tick();
      bus.data_valid_input = 1'b0;
      bus.data_input       = 2'b00;
      for (int i = 0; i < 8; i++) begin
         expect_out($sformatf("hit.show%0d", i), 1'b0, 2'b10, 1'b1, 1'b0, 1'b1);
         tick();
      end
      expect_out("hit.idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      expect_state("hit.idle", S_IDLE);

      // Timeout
      bus.lookup_request = 1'b1;
      tick();
      expect_out("to.req", 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      bus.lookup_request = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         expect_state($sformatf("to.wait%0d", i), S_WAIT);
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         expect_state($sformatf("to.miss%0d", i), S_SHOW_MISS);
         expect_out($sformatf("to.miss%0d", i), 1'b0, 2'b00, 1'b0, miss_pat[i], 1'b1);
         tick();
      end
      expect_out("to.idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

      // Valid on the last WAIT cycle wins over timeout
      bus.lookup_request = 1'b1;
      tick();
      bus.lookup_request = 1'b0;
      repeat (4) tick();
      expect_state("sim.wait3", S_WAIT);
      bus.data_valid_input = 1'b1;
      bus.data_input       = 2'b01;
      tick();
      bus.data_valid_input = 1'b0;
      bus.data_input       = 2'b00;
      for (int i = 0; i < 8; i++) begin
         expect_out($sformatf("sim.show%0d", i), 1'b0, 2'b01, 1'b1, 1'b0, 1'b1);
         tick();
      end
      expect_out("sim.idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

      // Edge ignored during WAIT, retrigger during SHOW_HIT
      bus.lookup_request = 1'b1;
      tick();
      expect_out("rt.req", 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      bus.lookup_request = 1'b0;
      tick();
      bus.lookup_request = 1'b1;
      tick();
      expect_out("rt.wait_edge", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      expect_state("rt.wait_edge", S_WAIT);
      bus.lookup_request = 1'b0;
      tick();
      expect_out("rt.wait2", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      bus.data_valid_input = 1'b1;
      bus.data_input       = 2'b11;
      tick();
      bus.data_valid_input = 1'b0;
      bus.data_input       = 2'b00;
      expect_out("rt.show0", 1'b0, 2'b11, 1'b1, 1'b0, 1'b1);
      tick();
      tick();
      expect_out("rt.show2", 1'b0, 2'b11, 1'b1, 1'b0, 1'b1);
      bus.lookup_request = 1'b1;
      tick();
      expect_out("rt.retrig", 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      expect_state("rt.retrig", S_REQUEST);
      bus.lookup_request = 1'b0;
      tick();
      expect_out("rt.wait", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

      // Reset mid SHOW_MISS with the button held across it
      repeat (4) tick();
      expect_out("rst.miss0", 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
      tick();
      bus.lookup_request = 1'b1;
      sync_reset_n       = 1'b0;
      tick();
      expect_out("rst.after", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      expect_state("rst.after", S_IDLE);
      sync_reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out($sformatf("rst.held%0d", i), 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      end
      bus.lookup_request = 1'b0;
      tick();
      bus.lookup_request = 1'b1;
      tick();
      expect_out("rst.repress", 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      bus.lookup_request = 1'b0;

      // Reset pulse between edges must not act
      sync_reset_n = 1'b0;
      #3;
      sync_reset_n = 1'b1;
      tick();
      expect_state("async.glitch", S_WAIT);
      expect_out("async.glitch", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
